// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: funct3 encodings and request legality shared by the memory responder
package mem_responder_pkg;
  typedef enum logic [2:0] {LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd4, LHU = 3'd5} ld_size_e;
  typedef enum logic [2:0] {SB = 3'd0, SH = 3'd1, SW = 3'd2} st_size_e;
  function automatic logic req_error(input logic we, input logic [2:0] size, input logic [1:0] lo);
    logic ok;
    ok = we ? size <= SW : (size <= LW || size == LBU || size == LHU);
    return !ok || (size[1:0] == 2'd1 && lo[0]) || (size[1:0] == 2'd2 && lo != 2'd0);
  endfunction
endpackage

// File: rtl/mem_lane_fmt.sv
// mem_lane_fmt: byte/halfword lane select with extension for loads and lane merge for sub-word stores
module mem_lane_fmt
  import mem_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lo,
  input  logic [2:0]  size,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_data
);
  logic [4:0] sh;
  logic [31:0] lane, mask;
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    sh = size[1:0] == 2'd1 ? {lo[1], 4'b0} : {lo, 3'b0};
    lane = word >> sh;
    b = lane[7:0];
    h = lane[15:0];
    mask = (size[1:0] == 2'd1 ? 32'h0000_ffff : 32'h0000_00ff) << sh;
    ld_data = size == LB  ? {{24{b[7]}}, b} :
              size == LH  ? {{16{h[15]}}, h} :
              size == LBU ? {24'b0, b} :
              size == LHU ? {16'b0, h} : word;
    st_data = size == SW ? wdata : (word & ~mask) | ((wdata << sh) & mask);
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding load/store responder in front of a synchronous word RAM
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              req_we,
  input  logic [2:0]        req_size,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  input  logic [31:0]       ram_rdata
);
  typedef enum logic [2:0] {IDLE, READ, LD_CAP, RMW_RD, RMW_WR, WRITE, RESP} state_e;
  state_e state, state_nx;
  logic [ADDR_W+1:0] addr;
  logic [31:0] wdata, ld_data, st_data;
  logic [2:0] size;
  logic accept, err, unused_addr;
  assign accept = req_valid && req_ready;
  assign err = req_error(req_we, req_size, req_addr[1:0]);
  // address bits above the RAM size are dropped so accesses wrap
  assign unused_addr = ^req_addr[31:ADDR_W+2];
  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:           if (accept) state_nx = err ? RESP : !req_we ? READ : req_size == SW ? WRITE : RMW_RD;
      READ:           state_nx = LD_CAP;
      LD_CAP:         state_nx = RESP;
      RMW_RD:         state_nx = RMW_WR;
      RMW_WR, WRITE:  state_nx = RESP;
      default:        state_nx = IDLE;
    endcase
  end
  always_comb begin
    req_ready = state == IDLE;
    resp_valid = state == RESP;
    ram_we = reset && (state == WRITE || state == RMW_WR);
    ram_wdata = state == WRITE ? wdata : st_data;
    ram_addr = addr[ADDR_W+1:2];
  end
  always_ff @(posedge clk)
    if (accept) begin
      addr <= req_addr[ADDR_W+1:0];
      wdata <= req_wdata;
      size <= req_size;
    end
  always_ff @(posedge clk)
    if (!reset) begin
      resp_err <= 1'b0;
      resp_rdata <= '0;
    end else if (accept) begin
      resp_err <= err;
      resp_rdata <= '0;
    end else if (state == LD_CAP) begin
      resp_rdata <= ld_data;
    end else if (state == RESP) begin
      resp_err <= 1'b0;
      resp_rdata <= '0;
    end
  mem_lane_fmt u_fmt (
    .word(ram_rdata),
    .lo(addr[1:0]),
    .size(size),
    .wdata(wdata),
    .ld_data(ld_data),
    .st_data(st_data)
  );
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized and directed bench against a byte-addressed memory model
module tb_mem_responder;
  localparam int AW = 10;
  logic clk = 0, reset = 0, req_valid = 0, req_ready, req_we = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, resp_rdata, ram_wdata, ram_rdata;
  logic [2:0] req_size = 0;
  logic resp_valid, resp_err, ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0] ram [1024];
  logic [7:0] mb [4096];
  typedef struct {int due; int acc; logic err; logic [31:0] rdata;} exp_t;
  exp_t q[$];
  int cyc = 0, n_chk = 0, n_pass = 0, we_cnt = 0, we_exp = 0, last_lat = 0;
  logic [31:0] last_rdata;
  logic last_err;

  mem_responder #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we), .req_size(req_size),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we === 1'b1) begin
      ram[ram_addr] <= ram_wdata;
      we_cnt <= we_cnt + 1;
    end
    ram_rdata <= ram[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h at cycle %0d", nm, got, want, cyc);
  endtask

  // Memory as little-endian bytes; accesses wrap at 4 KiB.
  function automatic void model(input logic [31:0] a, input logic [31:0] d, input logic we,
                                input logic [2:0] sz, input bit commit,
                                output logic err, output logic [31:0] rd, output int lat);
    int b, n;
    bit ok;
    b = int'(a[11:0]);
    n = sz[1:0] == 2'd0 ? 1 : sz[1:0] == 2'd1 ? 2 : 4;
    ok = we ? (sz inside {3'd0, 3'd1, 3'd2}) : (sz inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err = !ok || (b % n != 0);
    rd = 0;
    if (err) lat = 1;
    else if (we) begin
      lat = sz == 3'd2 ? 2 : 3;
      if (commit) for (int i = 0; i < n; i++) mb[b + i] = d[8*i +: 8];
    end else begin
      lat = 3;
      for (int i = 0; i < n; i++) rd = rd | ({24'b0, mb[b + i]} << (8 * i));
      if (!sz[2] && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8 * n));
    end
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic we,
                       input logic [2:0] sz, input bit commit);
    int t = 0, lat;
    logic e;
    logic [31:0] rd;
    do begin @(negedge clk); #1; t++; end while (!req_ready && t < 50);
    if (!req_ready) chk("accept_timeout", 32'(req_ready), 1);
    req_addr = a; req_wdata = d; req_we = we; req_size = sz; req_valid = 1;
    model(a, d, we, sz, commit, e, rd, lat);
    if (!e && we && commit) we_exp++;
    q.push_back('{due: cyc + lat, acc: cyc + 1, err: e, rdata: rd});
  endtask

  task automatic idle();
    @(negedge clk); #1;
    req_valid = 0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() > 0 && t < 50) begin @(negedge clk); #2; t++; end
    chk("drain", q.size(), 0);
  endtask

  task automatic single(input logic [31:0] a, input logic [31:0] d, input logic we, input logic [2:0] sz);
    issue(a, d, we, sz, 1);
    idle();
    drain();
  endtask

  task automatic abort(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
    issue(a, d, 1, sz, 0);
    @(negedge clk); #1;
    req_valid = 0;
    reset = 0;
    q.delete();
    #1 chk("we_in_reset", 32'(ram_we), 0);
    @(negedge clk); #1;
    reset = 1;
    repeat (4) @(negedge clk);
  endtask

  always @(negedge clk)
    if (reset === 1'b1) begin
      automatic bit exp_v = q.size() > 0 && q[0].due == cyc;
      chk("resp_valid", 32'(resp_valid), 32'(exp_v));
      chk("req_ready", 32'(req_ready), 32'(q.size() == 0));
      if (resp_valid && q.size() > 0) begin
        chk("resp_err", 32'(resp_err), 32'(q[0].err));
        chk("resp_rdata", resp_rdata, q[0].rdata);
        last_rdata = resp_rdata;
        last_err = resp_err;
        last_lat = cyc - q[0].acc + 1;
        void'(q.pop_front());
      end else if (exp_v) void'(q.pop_front());
    end

  initial begin
    int we0, mism;
    for (int i = 0; i < 1024; i++) ram[i] = 0;
    for (int i = 0; i < 4096; i++) mb[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_err", 32'(resp_err), 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    #1 reset = 1;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 1);

    single(32'h8, 32'hDEADBEEF, 1, 3'd2);
    chk("sw_lat", last_lat, 2);
    chk("sw_word2", ram[2], 32'hDEADBEEF);
    single(32'h8, 0, 0, 3'd2);
    chk("lw_data", last_rdata, 32'hDEADBEEF);
    chk("lw_lat", last_lat, 3);
    single(32'h9, 32'h12, 1, 3'd0);
    chk("sb_lat", last_lat, 3);
    chk("sb_word2", ram[2], 32'hDEAD12EF);
    single(32'hB, 0, 0, 3'd0);
    chk("lb_data", last_rdata, 32'hFFFFFFDE);
    single(32'hB, 0, 0, 3'd4);
    chk("lbu_data", last_rdata, 32'h000000DE);
    single(32'hA, 32'h8001, 1, 3'd1);
    chk("sh_word2", ram[2], 32'h800112EF);
    single(32'hA, 0, 0, 3'd1);
    chk("lh_data", last_rdata, 32'hFFFF8001);
    single(32'hA, 0, 0, 3'd5);
    chk("lhu_data", last_rdata, 32'h00008001);

    we0 = we_cnt;
    single(32'h6, 0, 0, 3'd2);
    chk("err_lw6", {last_rdata[30:0], last_err}, 1);
    chk("err_lat", last_lat, 1);
    single(32'h3, 0, 0, 3'd1);
    chk("err_lh3", {last_rdata[30:0], last_err}, 1);
    single(32'h2, 32'hFFFF_FFFF, 1, 3'd2);
    chk("err_sw2", {last_rdata[30:0], last_err}, 1);
    chk("err_sw2_lat", last_lat, 1);
    single(32'h8, 0, 0, 3'd3);
    chk("err_f3", {last_rdata[30:0], last_err}, 1);
    chk("err_no_we", we_cnt, we0);

    abort(32'h8, 32'h55, 3'd0);
    chk("abort_sb_word2", ram[2], 32'h800112EF);
    abort(32'h10, 32'hAAAA5555, 3'd2);
    chk("abort_sw_word4", ram[4], 0);
    chk("abort_no_we", we_cnt, we0);

    single(32'h1000, 32'hCAFEF00D, 1, 3'd2);
    chk("wrap_word0", ram[0], 32'hCAFEF00D);

    // back-to-back with req_valid held high
    issue(32'h20, 32'h11223344, 1, 3'd2, 1);
    issue(32'h21, 32'h0, 0, 3'd0, 1);
    issue(32'h22, 32'h9ABC, 1, 3'd1, 1);
    issue(32'h20, 32'h0, 0, 3'd2, 1);
    issue(32'h7, 32'h0, 0, 3'd2, 1);
    idle();
    drain();
    chk("b2b_last_err", 32'(last_err), 1);

    for (int i = 0; i < 300; i++) begin
      issue(($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63)), $urandom,
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1);
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();
    drain();

    mism = 0;
    for (int w = 0; w < 1024; w++)
      if (ram[w] !== {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]}) mism++;
    chk("ram_image", mism, 0);
    chk("we_count", we_cnt, we_exp);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
